// File: rtl/uart2bus_pkg.sv
// Shared command/response codes and sequencer state encoding for the uart2bus bridge.
package uart2bus_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Loadable up-counter that saturates at LIMIT; tc_o is high while the count equals LIMIT.
// Clear has priority over load, and load has priority over count enable.
module ctrl_timeout #(
  parameter int          W     = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// UART command sequencer: parses 0x57/0x52 frames, runs one bus access, returns one response byte.
// Request rises the cycle after the last command byte; response is held until tx_ready_in; rx has no backpressure.
module uart_bus_ctrl
  import uart2bus_pkg::*;
#(
  parameter int          AW           = 16,
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic          CLK_in,
  input  logic          nRST_in,
  input  logic [7:0]    rx_data_in,
  input  logic          rx_valid_in,
  output logic [7:0]    tx_data_out,
  output logic          tx_valid_out,
  input  logic          tx_ready_in,
  output logic [AW-1:0] bus_addr_out,
  output logic [7:0]    bus_wdata_out,
  output logic          bus_wr_out,
  output logic          bus_rd_out,
  input  logic [7:0]    bus_rdata_in,
  input  logic          bus_ack_in,
  output logic          LED_out
);

  localparam int BYW = $clog2(BYTE_TIMEOUT + 1);
  localparam int BUW = $clog2(BUS_TIMEOUT + 1);

  state_e        state_q;
  logic          is_wr_q;
  logic [7:0]    addr_hi_q;
  logic [AW-1:0] bus_addr_q;
  logic [7:0]    bus_wdata_q;
  logic          bus_wr_q, bus_rd_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          led_q;

  logic in_frame, byte_clr_d, bus_clr_d, byte_tc, bus_tc;

  // Byte timer only runs mid-frame and restarts on every received byte.
  assign in_frame   = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) || (state_q == ST_DATA);
  assign byte_clr_d = !in_frame || rx_valid_in;
  assign bus_clr_d  = (state_q != ST_BUS);

  ctrl_timeout #(.W(BYW), .LIMIT(BYTE_TIMEOUT - 1)) u_byte_to (
    .clk_i      (CLK_in),
    .rst_ni     (nRST_in),
    .clr_i      (byte_clr_d),
    .en_i       (1'b1),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_o       (byte_tc)
  );

  // Terminal count one below BUS_TIMEOUT so the request is high for exactly BUS_TIMEOUT cycles.
  ctrl_timeout #(.W(BUW), .LIMIT(BUS_TIMEOUT - 1)) u_bus_to (
    .clk_i      (CLK_in),
    .rst_ni     (nRST_in),
    .clr_i      (bus_clr_d),
    .en_i       (1'b1),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_o       (bus_tc)
  );

  always_ff @(posedge CLK_in) begin
    if (!nRST_in) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      addr_hi_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid_in) begin
            if (is_cmd(rx_data_in)) begin
              is_wr_q <= (rx_data_in == CMD_WR);
              state_q <= ST_ADDR_H;
            end else begin
              tx_data_q  <= RSP_NAK;
              tx_valid_q <= 1'b1;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_ADDR_H: begin
          if (rx_valid_in) begin
            addr_hi_q <= rx_data_in;
            state_q   <= ST_ADDR_L;
          end else if (byte_tc) begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADDR_L: begin
          if (rx_valid_in) begin
            bus_addr_q <= AW'({addr_hi_q, rx_data_in});
            if (is_wr_q) begin
              state_q <= ST_DATA;
            end else begin
              bus_rd_q <= 1'b1;
              state_q  <= ST_BUS;
            end
          end else if (byte_tc) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (rx_valid_in) begin
            bus_wdata_q <= rx_data_in;
            bus_wr_q    <= 1'b1;
            state_q     <= ST_BUS;
          end else if (byte_tc) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUS: begin
          // An ack landing on the terminal-count cycle still counts as success.
          if (bus_ack_in) begin
            bus_wr_q   <= 1'b0;
            bus_rd_q   <= 1'b0;
            tx_data_q  <= is_wr_q ? RSP_OK : bus_rdata_in;
            tx_valid_q <= 1'b1;
            led_q      <= ~led_q;
            state_q    <= ST_RESP;
          end else if (bus_tc) begin
            bus_wr_q   <= 1'b0;
            bus_rd_q   <= 1'b0;
            tx_data_q  <= RSP_NAK;
            tx_valid_q <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_ready_in) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data_out   = tx_data_q;
  assign tx_valid_out  = tx_valid_q;
  assign bus_addr_out  = bus_addr_q;
  assign bus_wdata_out = bus_wdata_q;
  assign bus_wr_out    = bus_wr_q;
  assign bus_rd_out    = bus_rd_q;
  assign LED_out       = led_q;

endmodule
